// File: rtl/ip_pkg.sv
// ip_pkg: state encoding, error codes and constants shared by the IPv4 receive path.
package ip_pkg;
    typedef enum logic [2:0] {IDLE, HDR, OPT, PAY, PAD, DRAIN} ip_state_t;
    typedef enum logic [2:0] {
        E_NONE    = 3'd0,
        E_VERSION = 3'd1,
        E_IHL     = 3'd2,
        E_CHKSUM  = 3'd3,
        E_DEST    = 3'd4,
        E_LENGTH  = 3'd5,
        E_TRUNC   = 3'd6
    } ip_err_t;
    localparam logic [3:0]  IP_VERSION   = 4'd4;
    localparam logic [3:0]  MIN_IHL      = 4'd5;
    localparam logic [31:0] BROADCAST_IP = 32'hFFFF_FFFF;
    function automatic logic [15:0] hdr_bytes(input logic [3:0] ihl);
        return {10'd0, ihl, 2'b00};
    endfunction
endpackage

// File: rtl/ones_comp_acc16.sv
// ones_comp_acc16: one's-complement accumulator of 32-bit words; fold includes the word added this cycle.
module ones_comp_acc16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        add,
    input  logic [31:0] data,
    output logic [15:0] fold
);
    logic [19:0] acc, base, acc_nxt;
    logic [16:0] f1;
    // Carries are wrapped back in on every add so a 15-word header cannot overflow 20 bits.
    always_comb begin
        base    = clr ? 20'd0 : {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
        acc_nxt = add ? base + {4'd0, data[31:16]} + {4'd0, data[15:0]} : base;
        f1      = {1'b0, acc_nxt[15:0]} + {13'd0, acc_nxt[19:16]};
        fold    = f1[15:0] + {15'd0, f1[16]};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc <= 20'd0;
        else if (add || clr) acc <= acc_nxt;
    end
endmodule

// File: rtl/ip_rx_decoder.sv
// ip_rx_decoder: IPv4 header decode/verify on a 32-bit word stream, forwarding accepted payload bytes.
module ip_rx_decoder
    import ip_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP     = 32'h980E_5E4B,
    parameter bit          DEST_FILTER  = 1'b1,
    parameter bit          CHKSUM_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [3:0]  version,
    output logic [3:0]  ihl,
    output logic [7:0]  type_of_ser,
    output logic [7:0]  time_to_live,
    output logic [7:0]  protocol,
    output logic [15:0] total_length,
    output logic [15:0] identification,
    output logic [2:0]  flag,
    output logic [12:0] frag_offset,
    output logic [31:0] src_ip,
    output logic [31:0] dest_ip,
    output logic [15:0] hdr_chksum,
    output logic        hdr_valid,
    output logic [15:0] len_out,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        done,
    output logic        ok,
    output logic [2:0]  err
);
    ip_state_t   state, state_nxt;
    ip_err_t     err_r, err_nxt, w0_err, eoh_err;
    logic [15:0] rem, len0, fold;
    logic [3:0]  hidx, pay_keep;
    logic [31:0] dst_now;
    logic        word0, acc_add, frame_end, hdr_end, hdr_ok, pay_fire, pay_last;

    ones_comp_acc16 u_acc (
        .clk  (clk),
        .reset(reset),
        .clr  (word0),
        .add  (acc_add),
        .data (in_data),
        .fold (fold)
    );

    assign word0     = in_valid && state == IDLE;
    assign acc_add   = in_valid && (state == IDLE || state == HDR || state == OPT);
    assign frame_end = in_valid && in_last;
    assign len0      = in_data[15:0] - hdr_bytes(in_data[27:24]);
    assign hdr_end   = in_valid && ((state == HDR && hidx == 4'd4 && ihl == MIN_IHL) ||
                                    (state == OPT && hidx == ihl - 4'd1));
    // Without options the destination word is the one arriving now, not yet registered.
    assign dst_now   = state == HDR ? in_data : dest_ip;
    assign pay_fire  = in_valid && state == PAY;
    assign pay_last  = rem <= 16'd4;
    assign pay_keep  = rem < 16'd4 ? ~(4'hF >> rem[1:0]) : 4'hF;

    always_comb begin
        w0_err = (in_data[31:28] != IP_VERSION) ? E_VERSION :
                 (in_data[27:24] < MIN_IHL) ? E_IHL :
                 (in_data[15:0] < hdr_bytes(in_data[27:24])) ? E_LENGTH : E_NONE;
        eoh_err = (CHKSUM_CHECK && fold != 16'hFFFF) ? E_CHKSUM :
                  (DEST_FILTER && dst_now != LOCAL_IP && dst_now != BROADCAST_IP) ? E_DEST : E_NONE;
        state_nxt = state;
        err_nxt   = err_r;
        hdr_ok    = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    err_nxt   = (w0_err == E_NONE && in_last) ? E_TRUNC : w0_err;
                    state_nxt = w0_err == E_NONE ? HDR : DRAIN;
                end
                HDR, OPT: begin
                    if (hdr_end) begin
                        hdr_ok    = eoh_err == E_NONE;
                        err_nxt   = (hdr_ok && in_last && len_out != 16'd0) ? E_TRUNC : eoh_err;
                        state_nxt = !hdr_ok ? DRAIN : len_out == 16'd0 ? PAD : PAY;
                    end else begin
                        err_nxt   = in_last ? E_TRUNC : err_r;
                        state_nxt = hidx == 4'd4 ? OPT : state;
                    end
                end
                PAY: begin
                    err_nxt   = (in_last && !pay_last) ? E_TRUNC : err_r;
                    state_nxt = pay_last ? PAD : PAY;
                end
                default: ;
            endcase
            if (in_last) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            version        <= '0;
            ihl            <= '0;
            type_of_ser    <= '0;
            total_length   <= '0;
            identification <= '0;
            flag           <= '0;
            frag_offset    <= '0;
            time_to_live   <= '0;
            protocol       <= '0;
            src_ip         <= '0;
            dest_ip        <= '0;
            hdr_chksum     <= '0;
            hdr_valid      <= 1'b0;
            len_out        <= '0;
            rem            <= '0;
            hidx           <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_keep       <= '0;
            out_last       <= 1'b0;
            done           <= 1'b0;
            ok             <= 1'b0;
            err            <= '0;
            err_r          <= E_NONE;
        end else begin
            if (word0) begin
                version      <= in_data[31:28];
                ihl          <= in_data[27:24];
                type_of_ser  <= in_data[23:16];
                total_length <= in_data[15:0];
                len_out      <= len0;
                rem          <= len0;
                hidx         <= 4'd1;
            end
            if (in_valid && (state == HDR || state == OPT)) hidx <= hidx + 4'd1;
            if (in_valid && state == HDR && hidx == 4'd1) {identification, flag, frag_offset} <= in_data;
            if (in_valid && state == HDR && hidx == 4'd2) {time_to_live, protocol} <= in_data[31:16];
            if (in_valid && state == HDR && hidx == 4'd3) src_ip <= in_data;
            if (in_valid && state == HDR && hidx == 4'd4) dest_ip <= in_data;
            if (hdr_end) hdr_chksum <= fold;
            hdr_valid <= hdr_ok;
            if (pay_fire) begin
                rem      <= rem - 16'd4;
                out_data <= in_data;
            end
            out_valid <= pay_fire;
            out_keep  <= pay_fire ? pay_keep : 4'h0;
            out_last  <= pay_fire && (pay_last || in_last);
            done      <= frame_end;
            if (frame_end) begin
                ok  <= err_nxt == E_NONE;
                err <= err_nxt;
            end
            err_r <= frame_end ? E_NONE : err_nxt;
        end
    end
endmodule

// File: tb/tb_ip_rx_decoder.sv
// tb_ip_rx_decoder: directed frames with a scoreboard of expected payload words, header pulses and frame status.
module tb_ip_rx_decoder;
    localparam logic [31:0] LOCAL = 32'h980E_5E4B;

    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  version, ihl, out_keep;
    logic [7:0]  type_of_ser, time_to_live, protocol;
    logic [15:0] total_length, identification, hdr_chksum, len_out;
    logic [2:0]  flag, err;
    logic [12:0] frag_offset;
    logic [31:0] src_ip, dest_ip, out_data;
    logic        hdr_valid, out_valid, out_last, done, ok;

    logic [3:0]  d2_version, d2_ihl, d2_out_keep;
    logic [7:0]  d2_tos, d2_ttl, d2_protocol;
    logic [15:0] d2_total_length, d2_identification, d2_hdr_chksum, d2_len_out;
    logic [2:0]  d2_flag, d2_err;
    logic [12:0] d2_frag_offset;
    logic [31:0] d2_src_ip, d2_dest_ip, d2_out_data;
    logic        d2_hdr_valid, d2_out_valid, d2_out_last, d2_done, d2_ok;

    ip_rx_decoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .version(version), .ihl(ihl), .type_of_ser(type_of_ser), .time_to_live(time_to_live),
        .protocol(protocol), .total_length(total_length), .identification(identification),
        .flag(flag), .frag_offset(frag_offset), .src_ip(src_ip), .dest_ip(dest_ip),
        .hdr_chksum(hdr_chksum), .hdr_valid(hdr_valid), .len_out(len_out),
        .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .done(done), .ok(ok), .err(err)
    );

    ip_rx_decoder #(.CHKSUM_CHECK(1'b0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .version(d2_version), .ihl(d2_ihl), .type_of_ser(d2_tos), .time_to_live(d2_ttl),
        .protocol(d2_protocol), .total_length(d2_total_length), .identification(d2_identification),
        .flag(d2_flag), .frag_offset(d2_frag_offset), .src_ip(d2_src_ip), .dest_ip(d2_dest_ip),
        .hdr_chksum(d2_hdr_chksum), .hdr_valid(d2_hdr_valid), .len_out(d2_len_out),
        .out_valid(d2_out_valid), .out_data(d2_out_data), .out_keep(d2_out_keep), .out_last(d2_out_last),
        .done(d2_done), .ok(d2_ok), .err(d2_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} pay_t;
    pay_t        exp_pay[$];
    logic [3:0]  exp_done[$];
    logic [15:0] exp_hdr[$];
    logic [31:0] fr[$];
    pay_t        e_p;
    logic [3:0]  e_d;
    logic [15:0] e_h;
    int          n_cmp = 0, n_bad = 0, d2_words = 0, d2_before;
    logic [3:0]  d2_st = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_pay.size() == 0) chk("unexpected_out_valid", 64'(out_data), 64'hDEAD_0000_0000);
            else begin
                e_p = exp_pay.pop_front();
                chk("out_data", 64'(out_data), 64'(e_p.d));
                chk("out_keep", 64'(out_keep), 64'(e_p.k));
                chk("out_last", 64'(out_last), 64'(e_p.l));
            end
        end
        if (hdr_valid) begin
            if (exp_hdr.size() == 0) chk("unexpected_hdr_valid", 64'(len_out), 64'hDEAD_0000_0000);
            else begin
                e_h = exp_hdr.pop_front();
                chk("len_out", 64'(len_out), 64'(e_h));
            end
        end
        if (done) begin
            if (exp_done.size() == 0) chk("unexpected_done", 64'({ok, err}), 64'hDEAD_0000_0000);
            else begin
                e_d = exp_done.pop_front();
                chk("ok_err", 64'({ok, err}), 64'(e_d));
            end
        end
    end

    always @(negedge clk) begin
        if (d2_out_valid) d2_words++;
        if (d2_done) d2_st <= {d2_ok, d2_err};
    end

    function automatic logic [15:0] calc_csum(input int n);
        logic [31:0] s = 0;
        for (int i = 0; i < n; i++) s += {16'd0, fr[i][31:16]} + {16'd0, fr[i][15:0]};
        while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    task automatic build(input logic [3:0] ver, input logic [3:0] ih, input logic [15:0] tl,
                         input logic [31:0] dst, input int n_opt);
        logic [31:0] t;
        fr.delete();
        fr.push_back({ver, ih, 8'h00, tl});
        fr.push_back(32'h1234_0123);
        fr.push_back({8'h10, 8'd17, 16'h0000});
        fr.push_back(32'h9801_331B);
        fr.push_back(dst);
        for (int i = 0; i < n_opt; i++) fr.push_back(32'h0A0B_0C00 + i);
        t = fr[2];
        t[15:0] = calc_csum(5 + n_opt);
        fr[2] = t;
    endtask

    task automatic hello();
        fr.push_back(32'h4865_6C6C);
        fr.push_back(32'h6F20_576F);
        fr.push_back(32'h726C_6400);
    endtask

    task automatic expect_hello();
        exp_hdr.push_back(16'd11);
        exp_pay.push_back({32'h4865_6C6C, 4'hF, 1'b0});
        exp_pay.push_back({32'h6F20_576F, 4'hF, 1'b0});
        exp_pay.push_back({32'h726C_6400, 4'hE, 1'b1});
        exp_done.push_back(4'b1000);
    endtask

    task automatic send(input bit gaps, input bit last);
        for (int i = 0; i < fr.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = fr[i];
            in_last  = last && (i == fr.size() - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_pending_out"}, 64'(exp_pay.size()), 64'd0);
        chk({name, "_pending_done"}, 64'(exp_done.size()), 64'd0);
        chk({name, "_pending_hdr"}, 64'(exp_hdr.size()), 64'd0);
    endtask

    function automatic logic any_out();
        return |{version, ihl, type_of_ser, time_to_live, protocol, total_length, identification,
                 flag, frag_offset, src_ip, dest_ip, hdr_chksum, hdr_valid, len_out, out_valid,
                 out_data, out_keep, out_last, done, ok, err};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", 64'(any_out()), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        build(4'd4, 4'd5, 16'd31, LOCAL, 0); hello(); expect_hello();
        send(1'b0, 1'b1);
        settle("clean");
        chk("version", 64'(version), 64'h4);
        chk("ihl", 64'(ihl), 64'h5);
        chk("tos", 64'(type_of_ser), 64'h0);
        chk("total_length", 64'(total_length), 64'd31);
        chk("identification", 64'(identification), 64'h1234);
        chk("flag", 64'(flag), 64'h0);
        chk("frag_offset", 64'(frag_offset), 64'h123);
        chk("ttl", 64'(time_to_live), 64'h10);
        chk("protocol", 64'(protocol), 64'd17);
        chk("src_ip", 64'(src_ip), 64'h9801_331B);
        chk("dest_ip", 64'(dest_ip), 64'h980E_5E4B);
        chk("hdr_chksum", 64'(hdr_chksum), 64'hFFFF);
        chk("len_out", 64'(len_out), 64'd11);

        build(4'd4, 4'd5, 16'd31, LOCAL, 0); fr[2] = fr[2] ^ 32'h1; hello();
        exp_done.push_back(4'b0011);
        d2_before = d2_words;
        send(1'b0, 1'b1);
        settle("bad_chksum");
        chk("nocheck_words", 64'(d2_words - d2_before), 64'd3);
        chk("nocheck_status", 64'(d2_st), 64'b1000);

        build(4'd4, 4'd7, 16'd32, LOCAL, 2); fr.push_back(32'hDEAD_BEEF);
        exp_hdr.push_back(16'd4);
        exp_pay.push_back({32'hDEAD_BEEF, 4'hF, 1'b1});
        exp_done.push_back(4'b1000);
        send(1'b0, 1'b1);
        settle("options");

        build(4'd6, 4'd5, 16'd31, LOCAL, 0); hello();
        exp_done.push_back(4'b0001);
        e_p.d = fr.pop_back();
        send(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("version_early_done", 64'(exp_done.size()), 64'd1);
        fr.delete(); fr.push_back(e_p.d);
        send(1'b0, 1'b1);
        settle("version");

        build(4'd4, 4'd5, 16'd31, 32'h0A00_0001, 0); hello();
        exp_done.push_back(4'b0100);
        send(1'b0, 1'b1);
        settle("dest");

        build(4'd4, 4'd5, 16'd31, 32'hFFFF_FFFF, 0); hello(); expect_hello();
        send(1'b0, 1'b1);
        settle("broadcast");

        build(4'd4, 4'd5, 16'd32, LOCAL, 0);
        fr.push_back(32'h1111_1111); fr.push_back(32'h2222_2222);
        exp_hdr.push_back(16'd12);
        exp_pay.push_back({32'h1111_1111, 4'hF, 1'b0});
        exp_pay.push_back({32'h2222_2222, 4'hF, 1'b1});
        exp_done.push_back(4'b0110);
        send(1'b0, 1'b1);
        settle("trunc");

        expect_hello(); expect_hello();
        build(4'd4, 4'd5, 16'd31, LOCAL, 0); hello();
        fr.push_back(32'h0); fr.push_back(32'h0); fr.push_back(32'h0);
        send(1'b1, 1'b1);
        build(4'd4, 4'd5, 16'd31, LOCAL, 0); hello();
        send(1'b0, 1'b1);
        settle("stress");

        build(4'd4, 4'd5, 16'd31, LOCAL, 0); hello();
        while (fr.size() > 6) void'(fr.pop_back());
        exp_hdr.push_back(16'd11);
        exp_pay.push_back({32'h4865_6C6C, 4'hF, 1'b0});
        send(1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midframe_reset_zero", 64'(any_out()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        build(4'd4, 4'd5, 16'd31, LOCAL, 0); hello(); expect_hello();
        send(1'b0, 1'b1);
        settle("after_reset");
        chk("after_reset_src", 64'(src_ip), 64'h9801_331B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
